// File: rtl/gfx256_pixel_writer_if.sv
// Port bundle for gfx256_pixel_writer: raster requests, framebuffer setup,
// the 256-bit memory bus and the color-merge side channel.
interface gfx256_pixel_writer_if;
  logic [31:0]  target_base_i;
  logic [15:0]  target_width_i;
  logic [5:0]   bpp_i;
  logic         flush_i;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [15:0]  x_i;
  logic [15:0]  y_i;
  logic [31:0]  color_i;
  logic         busy_o;
  logic         m_cyc_o;
  logic         m_stb_o;
  logic         m_we_o;
  logic [31:0]  m_adr_o;
  logic [31:0]  m_sel_o;
  logic [255:0] m_dat_o;
  logic [255:0] m_dat_i;
  logic         m_ack_i;
  logic         cm_rmw_o;
  logic [7:0]   cm_mb_o;
  logic [31:0]  cm_color_o;
  logic [255:0] cm_mem_o;
  logic [255:0] cm_mem_i;
  logic [31:0]  cm_sel_i;

  modport master (
    input  target_base_i, target_width_i, bpp_i, flush_i,
    input  req_valid_i, x_i, y_i, color_i,
    output req_ready_o, busy_o,
    output m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o, m_dat_o,
    input  m_dat_i, m_ack_i,
    output cm_rmw_o, cm_mb_o, cm_color_o, cm_mem_o,
    input  cm_mem_i, cm_sel_i
  );

  modport slave (
    output target_base_i, target_width_i, bpp_i, flush_i,
    output req_valid_i, x_i, y_i, color_i,
    input  req_ready_o, busy_o,
    input  m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o, m_dat_o,
    output m_dat_i, m_ack_i,
    input  cm_rmw_o, cm_mb_o, cm_color_o, cm_mem_o,
    output cm_mem_i, cm_sel_i
  );
endinterface

// File: rtl/gfx256_pixel_writer.sv
// Pixel write sequencer: (x,y,color) -> masked 256-bit bus write, with RMW read and one-word cache.
// Accept-to-ready 3 cycles (direct/cache hit) or 4 (RMW miss) at zero-wait; req_ready_o low while busy, bus held until ack.
module gfx256_pixel_writer (
  input  logic                  clk_i,
  input  logic                  rst_i,
  gfx256_pixel_writer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [15:0]  x_q;
  logic [15:0]  y_q;
  logic [31:0]  color_q;
  logic [31:0]  adr_q;
  logic [7:0]   mb_q;
  logic         rmw_q;
  logic [255:0] word_q;

  logic [255:0] cache_word;
  logic [31:0]  cache_adr;
  logic         cache_vld;

  logic [31:0]  lin_pix;
  logic [31:0]  bit_lo;
  logic [31:0]  calc_adr;
  logic         calc_rmw;
  logic         cache_hit;
  logic         accept;
  logic         unused_base;

  assign unused_base = ^bus.target_base_i[4:0];
  assign accept      = bus.req_valid_i && bus.req_ready_o;

  // Only the low 32 bits of the bit address reach the word address and offset,
  // so the product is carried modulo 2^32.
  always_comb begin
    lin_pix   = 32'(y_q) * 32'(bus.target_width_i) + 32'(x_q);
    bit_lo    = lin_pix * {26'd0, bus.bpp_i};
    calc_adr  = {bus.target_base_i[31:5], 5'd0} + {3'd0, bit_lo[31:8], 5'd0};
    calc_rmw  = bus.bpp_i < 6'd8;
    cache_hit = calc_rmw && cache_vld && (cache_adr == calc_adr);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    state_nxt = (calc_rmw && !cache_hit) ? READ : WRITE;
      READ:    if (bus.m_ack_i) state_nxt = WRITE;
      WRITE:   if (bus.m_ack_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cyc/stb stay high from READ straight into WRITE so the RMW keeps the bus locked.
  always_comb begin
    bus.req_ready_o = (state == IDLE) && !rst_i;
    bus.busy_o      = (state != IDLE);
    bus.m_cyc_o     = 1'b0;
    bus.m_stb_o     = 1'b0;
    bus.m_we_o      = 1'b0;
    bus.m_sel_o     = '0;
    bus.m_dat_o     = '0;
    unique case (state)
      READ: begin
        bus.m_cyc_o = 1'b1;
        bus.m_stb_o = 1'b1;
        bus.m_sel_o = '1;
      end
      WRITE: begin
        bus.m_cyc_o = 1'b1;
        bus.m_stb_o = 1'b1;
        bus.m_we_o  = 1'b1;
        bus.m_sel_o = bus.cm_sel_i;
        bus.m_dat_o = bus.cm_mem_i;
      end
      default: ;
    endcase
  end

  assign bus.m_adr_o    = adr_q;
  assign bus.cm_rmw_o   = rmw_q;
  assign bus.cm_mb_o    = mb_q;
  assign bus.cm_color_o = color_q;
  assign bus.cm_mem_o   = word_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      adr_q   <= '0;
      mb_q    <= '0;
      rmw_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      if (accept) begin
        x_q     <= bus.x_i;
        y_q     <= bus.y_i;
        color_q <= bus.color_i;
      end
      if (state == CALC) begin
        adr_q  <= calc_adr;
        mb_q   <= bit_lo[7:0];
        rmw_q  <= calc_rmw;
        word_q <= cache_hit ? cache_word : '0;
      end
      if ((state == READ) && bus.m_ack_i) begin
        word_q <= bus.m_dat_i;
      end
    end
  end

  // The cache mirrors the last RMW-written word; a direct write may alias it, so it drops out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cache_vld  <= 1'b0;
      cache_adr  <= '0;
      cache_word <= '0;
    end else begin
      if ((state == WRITE) && bus.m_ack_i && rmw_q) begin
        cache_adr  <= adr_q;
        cache_word <= bus.cm_mem_i;
      end
      if (bus.flush_i) begin
        cache_vld <= 1'b0;
      end else if ((state == WRITE) && bus.m_ack_i) begin
        cache_vld <= rmw_q;
      end
    end
  end

endmodule
